// File: rtl/wb_stream_writer_ctrl_pkg.sv
// wb_stream_writer_ctrl_pkg: FSM state encoding and Wishbone cycle-type constants
package wb_stream_writer_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, READ, DONE} state_e;
  localparam logic [2:0] CTI_CLASSIC      = 3'b000;
  localparam logic [2:0] CTI_INC_BURST    = 3'b010;
  localparam logic [2:0] CTI_END_OF_BURST = 3'b111;
endpackage

// File: rtl/wb_stream_writer_ctrl.sv
// wb_stream_writer_ctrl: Wishbone burst reader streaming a memory buffer into a FIFO
// Define WB_STREAM_WRITER_CTRL_CTI_EN for incrementing-burst cycle types; otherwise classic cycles.
module wb_stream_writer_ctrl
  import wb_stream_writer_ctrl_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 6,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [WB_AW-1:0]   wbm_adr_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic               wbm_ack_i,
  output logic [WB_DW-1:0]   fifo_d_o,
  output logic               fifo_dv_o,
  input  logic [FIFO_AW:0]   fifo_cnt_i,
  input  logic               enable_i,
  input  logic [WB_AW-1:0]   start_adr_i,
  input  logic [WB_AW-1:0]   buf_size_i,
  input  logic [WB_AW-1:0]   burst_size_i,
  output logic               busy_o,
  output logic               done_o
);
  state_e             state_q;
  logic [WB_AW-1:0]   base_q, adr_q, offset_q, remaining_q, beat_q, blen_q;
  logic [WB_DW-1:0]   fifo_d_q;
  logic               cyc_q, dv_q, busy_q, done_q, stop_q;
  logic [WB_AW-1:0]   bs, cap, blen, adr_cur;
  logic [FIFO_AW+1:0] space;
  logic               fits, last;

  assign bs      = burst_size_i == '0 ? WB_AW'(1) : burst_size_i;
  assign cap     = bs > WB_AW'(MAX_BURST_LEN) ? WB_AW'(MAX_BURST_LEN) : bs;
  assign blen    = cap > remaining_q ? remaining_q : cap;
  assign space   = (FIFO_AW+2)'(2**FIFO_AW) - (FIFO_AW+2)'(fifo_cnt_i);
  assign fits    = 64'(space) >= 64'(blen);
  assign last    = beat_q == blen_q - WB_AW'(1);
  assign adr_cur = base_q + (offset_q << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      adr_q       <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      blen_q      <= '0;
      fifo_d_q    <= '0;
      cyc_q       <= 1'b0;
      dv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (enable_i) begin
          base_q      <= start_adr_i;
          offset_q    <= '0;
          remaining_q <= buf_size_i;
          busy_q      <= buf_size_i != '0;
          done_q      <= buf_size_i == '0;
          state_q     <= buf_size_i == '0 ? DONE : WAIT_SPACE;
        end
        WAIT_SPACE: if (!enable_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (fits) begin
          state_q <= READ;
          cyc_q   <= 1'b1;
          adr_q   <= adr_cur;
          blen_q  <= blen;
          beat_q  <= '0;
          stop_q  <= 1'b0;
        end
        READ: begin
          if (!enable_i) stop_q <= 1'b1;
          if (wbm_ack_i) begin
            fifo_d_q    <= wbm_dat_i;
            dv_q        <= 1'b1;
            offset_q    <= offset_q + WB_AW'(1);
            remaining_q <= remaining_q - WB_AW'(1);
            beat_q      <= beat_q + WB_AW'(1);
            adr_q       <= adr_cur + WB_AW'(4);
            if (last) begin
              cyc_q <= 1'b0;
              // a stop request seen anywhere in the burst wins over completion
              if (stop_q || !enable_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else if (remaining_q == WB_AW'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= WAIT_SPACE;
              end
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_bte_o = 2'b00;
  assign fifo_d_o  = fifo_d_q;
  assign fifo_dv_o = dv_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
`ifdef WB_STREAM_WRITER_CTRL_CTI_EN
  assign wbm_cti_o = last ? CTI_END_OF_BURST : CTI_INC_BURST;
`else
  assign wbm_cti_o = CTI_CLASSIC;
`endif
endmodule

// File: doc/wb_stream_writer_ctrl.md
WB_STREAM_WRITER_CTRL -- requirements
Module: wb_stream_writer_ctrl

Interface
REQ-001 Parameter WB_AW, default 32, Wishbone byte-address width.
REQ-002 Parameter WB_DW, default 32, Wishbone/stream data width.
REQ-003 Parameter FIFO_AW, default 6, downstream FIFO depth width (depth = 2**FIFO_AW words).
REQ-004 Parameter MAX_BURST_LEN, default 16, maximum beats per Wishbone burst.
REQ-005 Ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wbm_adr_o  out  WB_AW  byte address, word-aligned
- wbm_dat_i  in  WB_DW  read data
- wbm_sel_o  out  WB_DW/8  byte select, all ones
- wbm_we_o  out  1  constant 0 (read-only master)
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type, constant 0
- wbm_ack_i  in  1  acknowledge
- fifo_d_o  out  WB_DW  data to FIFO write port
- fifo_dv_o  out  1  FIFO write strobe
- fifo_cnt_i  in  FIFO_AW+1  current FIFO fill level
- enable_i  in  1  run request
- start_adr_i  in  WB_AW  buffer base byte address
- buf_size_i  in  WB_AW  buffer length in words
- burst_size_i  in  WB_AW  requested beats per burst
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse

Function
REQ-006 FSM states IDLE, WAIT_SPACE, READ, DONE.
REQ-007 IDLE: enable_i=1 latches start_adr_i, buf_size_i into offset=0, remaining=buf_size_i; next WAIT_SPACE; busy_o=1 from the following cycle.
REQ-008 buf_size_i=0 at start: IDLE -> DONE directly, no bus cycle.
REQ-009 Burst length blen = min(burst_size_i, MAX_BURST_LEN, remaining); burst_size_i=0 treated as 1.
REQ-010 WAIT_SPACE -> READ only when 2**FIFO_AW - fifo_cnt_i >= blen, computed at FIFO_AW+2 bits (no wrap).
REQ-011 READ: wbm_cyc_o=wbm_stb_o=1; wbm_adr_o = start_adr + 4*offset, held until ack.
REQ-012 Each wbm_ack_i: fifo_d_o<=wbm_dat_i, fifo_dv_o=1 for exactly the next cycle; offset+1, remaining-1, beat count+1.
REQ-013 Last beat acked: cyc/stb drop next cycle; remaining=0 -> DONE, else WAIT_SPACE.
REQ-014 No ack: cyc/stb held indefinitely; no timeout.
REQ-015 DONE: done_o=1 one cycle, busy_o=0, return IDLE; new start requires enable_i sampled high in IDLE.
REQ-016 enable_i low during READ: current burst completes, then IDLE, no done_o; low during WAIT_SPACE: IDLE next cycle.
REQ-017 FIFO never overflows: total fifo_dv_o pulses per burst equal blen, guaranteed by REQ-010.

Reset
REQ-018 rst: state IDLE; cyc, stb, fifo_dv_o, busy_o, done_o = 0; adr, offset, remaining, beat count = 0; fifo_d_o = 0.
REQ-019 rst mid-burst: cyc/stb drop next edge; partial burst abandoned, no further FIFO writes.

Configuration
REQ-020 Macro WB_STREAM_WRITER_CTRL_CTI_EN defined: wbm_cti_o=3'b010 on all but last beat, 3'b111 on last beat; blen=1 uses 3'b111.
REQ-021 Macro undefined: wbm_cti_o=3'b000 on every beat (classic cycles); all other behaviour identical.

Structure
REQ-022 Shared package holds FSM state encoding and CTI constants (CLASSIC, INC_BURST, END_OF_BURST).
REQ-023 Single module; no sub-module.

Verification
REQ-024 start=0x1000, size=8, burst=4, FIFO empty -> two bursts adr 0x1000..0x100C, 0x1010..0x101C; 8 fifo_dv_o; one done_o.
REQ-025 FIFO_AW=6, fifo_cnt_i=62, burst=4 -> stays WAIT_SPACE; fifo_cnt_i=60 -> READ next cycle.
REQ-026 size=10, burst=4 -> bursts of 4,4,2; with CTI_EN last-beat cti=3'b111 on beats 4, 8, 10.
REQ-027 size=0 -> no cyc_o, done_o one cycle after start.
REQ-028 enable_i dropped on beat 2 of 4 -> beats 3,4 complete, IDLE, no done_o; rst on beat 2 -> cyc_o=0 next cycle, no further fifo_dv_o.
